// File: rtl/debounce_multi.sv
// ---------------------------------------------------------------------------
// debounce_multi
//
// Parametrised N-channel debouncer for pushbuttons and switches. It replaces
// the older fixed 5-button/8-switch debouncer. Every raw input is brought into
// the clk domain through a flop chain. It is then sampled on a shared
// prescaled tick and filtered by a stability counter that belongs to that
// channel alone. The block reports the clean level and one-cycle edge pulses.
// It also exports the sample tick so that neighbouring blocks can share it.
//
// Build option: DEBOUNCE_AUTOREPEAT_EN
//   - When defined, each channel gets a press/auto-repeat FSM that drives
//     key_pulse.
//   - When undefined, key_pulse is simply the rise pulse.
//
// Ports
//   clk        : system clock (100 MHz)
//   rst        : asynchronous active-high reset; every output reads 0 while it
//                is high
//   raw_in     : [NUM_CH] unsynchronised button/switch levels
//   db_out     : [NUM_CH] debounced levels
//   rise_pulse : [NUM_CH] one clk cycle on each debounced 0->1 transition
//   fall_pulse : [NUM_CH] one clk cycle on each debounced 1->0 transition
//   key_pulse  : [NUM_CH] press event, plus the auto-repeat events when that
//                option is built
//   tick       : one-cycle sample strobe, every TICK_DIV clk cycles
// ---------------------------------------------------------------------------
module debounce_multi #(
  parameter int NUM_CH             = 13,
  parameter int SYNC_STAGES        = 2,
  parameter int TICK_DIV           = 100000,
  parameter int STABLE_TICKS       = 5,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] db_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] key_pulse,
  output logic              tick
);

  // Reject configurations the datapath cannot represent. The repeat
  // parameters only matter when auto-repeat is built, but they are held to
  // the same sanity rule in every build so that the same instance stays
  // legal under either build option.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be >= 2");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("debounce_multi: TICK_DIV must be >= 1");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable
    $error("debounce_multi: STABLE_TICKS must be >= 1");
  end
  if (REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_bad_repeat
    $error("debounce_multi: REPEAT_*_TICKS must be >= 1");
  end

  // With TICK_DIV == 1 the prescaler collapses to a single flop that stays
  // at 0, which keeps tick permanently high.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  // Synchroniser chain
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_d;
  logic [NUM_CH-1:0]                  sync_in;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Sample-tick prescaler
  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick_raw;

  assign tick_raw = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (tick_raw) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // The prescaler idles at 0 in reset. That value would already decode as a
  // tick when TICK_DIV == 1, so the exported strobe is masked while reset is
  // held.
  assign tick = tick_raw & ~rst;

  // Per-channel stability filter
  logic [NUM_CH-1:0][CW-1:0] cnt_q;
  logic [NUM_CH-1:0][CW-1:0] cnt_d;
  logic [NUM_CH-1:0]         db_q;
  logic [NUM_CH-1:0]         db_d;
  logic [NUM_CH-1:0]         db_prev_q;

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (tick_raw) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (sync_in[ch] == db_q[ch]) begin
          // One agreeing sample throws away any partial qualification.
          cnt_d[ch] = '0;
        end else if (cnt_q[ch] == CNT_LAST) begin
          db_d[ch]  = sync_in[ch];
          cnt_d[ch] = '0;
        end else begin
          cnt_d[ch] = cnt_q[ch] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

  // Edge pulses: both flops clear together in reset, so neither the
  // assertion nor the release of reset can produce a pulse.
  assign db_out     = db_q;
  assign rise_pulse = db_q & ~db_prev_q;
  assign fall_pulse = ~db_q & db_prev_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  // Per-channel press / auto-repeat FSM
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                        REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  rep_state_e        rep_state_q [NUM_CH];
  rep_state_e        rep_state_d [NUM_CH];
  logic [RW-1:0]     rep_cnt_q   [NUM_CH];
  logic [RW-1:0]     rep_cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] key_d;

  always_comb begin
    key_d = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      rep_state_d[ch] = rep_state_q[ch];
      rep_cnt_d[ch]   = rep_cnt_q[ch];
      if (!db_q[ch]) begin
        // Release overrides every state and suppresses any pending repeat,
        // including a repeat that would coincide with the release cycle.
        rep_state_d[ch] = ST_IDLE;
        rep_cnt_d[ch]   = '0;
      end else begin
        case (rep_state_q[ch])
          ST_IDLE: begin
            if (rise_pulse[ch]) begin
              rep_state_d[ch] = ST_DELAY;
              rep_cnt_d[ch]   = '0;
              key_d[ch]       = 1'b1;
            end
          end
          ST_DELAY: begin
            if (tick_raw) begin
              if (rep_cnt_q[ch] == DELAY_LAST) begin
                rep_state_d[ch] = ST_REPEAT;
                rep_cnt_d[ch]   = '0;
                key_d[ch]       = 1'b1;
              end else begin
                rep_cnt_d[ch] = rep_cnt_q[ch] + RW'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (tick_raw) begin
              if (rep_cnt_q[ch] == RATE_LAST) begin
                rep_cnt_d[ch] = '0;
                key_d[ch]     = 1'b1;
              end else begin
                rep_cnt_d[ch] = rep_cnt_q[ch] + RW'(1);
              end
            end
          end
          default: begin
            rep_state_d[ch] = ST_IDLE;
            rep_cnt_d[ch]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        rep_state_q[ch] <= ST_IDLE;
        rep_cnt_q[ch]   <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        rep_state_q[ch] <= rep_state_d[ch];
        rep_cnt_q[ch]   <= rep_cnt_d[ch];
      end
    end
  end

  // The press event coincides with rise_pulse. Each repeat event lands in
  // the tick cycle that completes its period.
  assign key_pulse = key_d;
`else
  assign key_pulse = rise_pulse;
`endif

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel debouncer and the successor to the fixed 5-button/8-switch debouncer.
- Synchronises raw pushbutton and switch inputs, samples them on a shared prescaled tick, and filters each channel with its own stability counter.
- Emits the debounced level plus one-cycle rise and fall pulses per channel.
- Sits between the board pins and the game interface, the video game controller and the seven-segment logic, all in the 100 MHz domain.

Parameters:
- NUM_CH, 13: number of independent input channels.
- SYNC_STAGES, 2: synchroniser flop depth; must be >= 2.
- TICK_DIV, 100000: clk cycles per sample tick (1 ms at 100 MHz); must be >= 1.
- STABLE_TICKS, 5: consecutive differing ticks required before db_out changes; must be >= 1.
- REPEAT_DELAY_TICKS, 500: ticks from press to first auto-repeat. Used only with the optional feature.
- REPEAT_RATE_TICKS, 100: ticks between subsequent auto-repeats. Used only with the optional feature.

Ports:
- clk, input, 1: system clock (100 MHz).
- rst, input, 1: asynchronous, active-high reset.
- raw_in, input, NUM_CH: unsynchronised button/switch inputs.
- db_out, output, NUM_CH: debounced levels.
- rise_pulse, output, NUM_CH: one-cycle pulse on each debounced 0->1 transition.
- fall_pulse, output, NUM_CH: one-cycle pulse on each debounced 1->0 transition.
- key_pulse, output, NUM_CH: press event, plus auto-repeat events when the optional feature is enabled.
- tick, output, 1: one-cycle sample strobe, exported for reuse by other blocks.

Behaviour:
- Reset: asynchronous, active-high. Clears all synchroniser flops, the prescaler, every stability counter, db_out, the pulse registers and the repeat state.
  - All outputs read 0 while rst is high.
  - No pulses are generated by reset assertion or release.
- Synchroniser: raw_in passes through SYNC_STAGES flops to give sync_in.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly the cycle in which count == TICK_DIV-1.
  - With TICK_DIV=1, tick is constantly high.
- Per-channel filter, evaluated only on cycles where tick is high:
  - If sync_in == db_out: cnt <= 0.
  - Else if cnt == STABLE_TICKS-1: db_out <= sync_in and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Counter width is clog2(STABLE_TICKS+1).
  - A single agreeing tick restarts the count; glitches shorter than STABLE_TICKS ticks never reach db_out.
- Latency: db_out changes SYNC_STAGES cycles plus STABLE_TICKS tick periods after a clean raw change, with up to one extra tick period of alignment error.
- Edge pulses: a registered copy db_d tracks db_out.
  - rise_pulse = db_out & ~db_d.
  - fall_pulse = ~db_out & db_d.
  - Each pulse is exactly one clk cycle, in the first cycle the new level is visible.
- Channels are fully independent. Simultaneous transitions on several channels produce their pulses in the same cycle.
- Reset mid-count discards the partial count. After release, a still-held input re-qualifies from zero.

Optional Feature:
- Macro: DEBOUNCE_AUTOREPEAT_EN.
- Defined: each channel has an FSM with states IDLE, DELAY and REPEAT, plus a repeat counter of width clog2(max(REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS)+1).
  - IDLE -> DELAY on rise_pulse. key_pulse fires this cycle and the counter clears.
  - DELAY: counter increments on each tick. When it reaches REPEAT_DELAY_TICKS-1 on a tick, go to REPEAT, fire key_pulse and clear the counter.
  - REPEAT: same as DELAY but using REPEAT_RATE_TICKS-1; fire key_pulse and clear each period.
  - db_out == 0 in any state returns the FSM to IDLE immediately and clears the counter; no further key_pulse is issued.
- Undefined: key_pulse = rise_pulse. No repeat FSM or counters are synthesised, and the REPEAT_* parameters are ignored.

Test Plan:
Bench parameters: NUM_CH=4, TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2, REPEAT_DELAY_TICKS=10, REPEAT_RATE_TICKS=5.
- Reset: assert rst asynchronously (not clock-aligned) while ch0 is mid-count with raw_in=4'b0001 -> all outputs 0 with no clk edge needed. Release with raw held -> db_out[0]=1 no earlier than 3 ticks later, and exactly one rise_pulse[0].
- Clean press: raw_in[0] 0->1, held 100 cycles -> db_out[0]=1 between 10 and 14 cycles after the edge; rise_pulse[0] high 1 cycle; fall_pulse=0; other channels unchanged.
- Glitch: raw_in[1] high for 6 cycles (at most 2 ticks), then low -> db_out[1] stays 0; rise_pulse and fall_pulse never assert.
- Simultaneous: with db_out[2]=1 settled, raw_in[1] 0->1 and raw_in[2] 1->0 in the same cycle -> rise_pulse[1] and fall_pulse[2] assert in the same cycle.
- Auto-repeat (macro defined): hold raw_in[3]=1 for 120 ticks -> key_pulse[3] at press, then 10 ticks later, then every 5 ticks. On release: a single fall_pulse[3] and no further key_pulse.
- Macro undefined: the same hold stimulus -> key_pulse[3] fires once only, identical in timing to rise_pulse[3].
